// File: rtl/cache_switch_pkg.sv
// Shared definitions for the cache-bank switch controller and the bank mux.
package cache_switch_pkg;

  localparam int SEL_W            = 5;
  localparam int DEFAULT_BANK_SEL = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/cache_switch_controller_settle_timer.sv
// Load/decrement down-counter that times the post-switch settle window.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SETTLE_CYCLES - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/cache_switch_controller.sv
// Sequences the cache-bank mux select on context-switch requests:
// drain the in-flight access, retarget, stall for a settle window, report done.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | ready for a request; invalid IDs are rejected here
//   ST_DRAIN  | CPU stalled, waiting for the outgoing cache to go idle
//   ST_SETTLE | select already changed, CPU stalled while the mux settles
//   ST_DONE   | one-cycle completion pulse, then back to IDLE
module cache_switch_controller #(
  parameter int NUM_BANKS     = 9,
  parameter int SEL_W         = cache_switch_pkg::SEL_W,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             switch_req,
  input  logic [SEL_W-1:0] switch_id,
  input  logic             cache_busy,
  output logic             switch_ready,
  output logic [SEL_W-1:0] bank_sel,
  output logic             cpu_stall,
  output logic             switch_done,
  output logic             switch_err,
  output logic [CNT_W-1:0] switch_count
);

  import cache_switch_pkg::*;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] target;
  logic             accept;
  logic             id_invalid;
  logic             retarget;
  logic             settle_dec;
  logic             settle_expired;
  logic             count_inc;

  assign id_invalid = (int'(switch_id) >= NUM_BANKS);

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    retarget   = 1'b0;
    settle_dec = 1'b0;
    count_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (switch_req) begin
          accept = 1'b1;
          if (id_invalid)
            state_nxt = ST_IDLE;
          else if (switch_id == bank_sel)
            state_nxt = ST_DONE;
          else
            state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!cache_busy) begin
          retarget  = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_dec = 1'b1;
        if (settle_expired) begin
          count_inc = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      target       <= '0;
      bank_sel     <= SEL_W'(DEFAULT_BANK_SEL);
      switch_err   <= 1'b0;
      switch_count <= '0;
    end else begin
      switch_err <= accept && id_invalid;
      if (accept)
        target <= switch_id;
      if (retarget)
        bank_sel <= target;
      if (count_inc && (switch_count != '1))
        switch_count <= switch_count + 1'b1;
    end
  end

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (retarget),
    .dec     (settle_dec),
    .expired (settle_expired)
  );

  // Stall covers DRAIN so it rises one cycle ahead of the select change.
  assign switch_ready = (state == ST_IDLE);
  assign cpu_stall    = (state == ST_DRAIN) || (state == ST_SETTLE);
  assign switch_done  = (state == ST_DONE);

endmodule

// File: tb/tb_cache_switch_controller.sv
// Directed and randomized checks of cache_switch_controller against a behavioural model.
module tb_cache_switch_controller;

  localparam int NB     = 9;
  localparam int SW     = 5;
  localparam int SETTLE = 2;
  localparam int CW     = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          switch_req = 1'b0;
  logic [SW-1:0] switch_id = '0;
  logic          cache_busy = 1'b0;
  logic          switch_ready;
  logic [SW-1:0] bank_sel;
  logic          cpu_stall;
  logic          switch_done;
  logic          switch_err;
  logic [CW-1:0] switch_count;

  int tests = 0;
  int fails = 0;

  cache_switch_controller #(
    .NUM_BANKS(NB), .SEL_W(SW), .SETTLE_CYCLES(SETTLE), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .switch_req(switch_req), .switch_id(switch_id),
    .cache_busy(cache_busy), .switch_ready(switch_ready), .bank_sel(bank_sel),
    .cpu_stall(cpu_stall), .switch_done(switch_done), .switch_err(switch_err),
    .switch_count(switch_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a pending drain, remaining settle cycles, a done pulse.
  bit m_drain = 0, m_done = 0, m_err = 0, started = 0;
  int m_settle = 0, m_sel = 0, m_cnt = 0, m_target = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_drain = 0; m_done = 0; m_err = 0; m_settle = 0; m_sel = 0; m_cnt = 0;
    end else begin
      m_err = 0;
      if (m_done) m_done = 0;
      else if (m_drain) begin
        if (!cache_busy) begin m_drain = 0; m_sel = m_target; m_settle = SETTLE; end
      end else if (m_settle > 0) begin
        m_settle--;
        if (m_settle == 0) begin
          m_done = 1;
          if (m_cnt != (1 << CW) - 1) m_cnt++;
        end
      end else if (switch_req) begin
        if (int'(switch_id) >= NB) m_err = 1;
        else if (int'(switch_id) == m_sel) m_done = 1;
        else begin m_drain = 1; m_target = int'(switch_id); end
      end
    end
    started = 1;
  end

  always @(negedge CLK) begin
    if (started) begin
      check("ready", 32'(switch_ready), 32'(!m_drain && m_settle == 0 && !m_done));
      check("stall", 32'(cpu_stall), 32'(m_drain || m_settle > 0));
      check("done", 32'(switch_done), 32'(m_done));
      check("err", 32'(switch_err), 32'(m_err));
      check("bank_sel", 32'(bank_sel), 32'(m_sel));
      check("count", 32'(switch_count), 32'(m_cnt));
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  initial begin
    step(3);
    RESET = 1'b0;
    step();
    check("lit_reset_sel", 32'(bank_sel), 32'd0);
    check("lit_reset_ready", 32'(switch_ready), 32'd1);

    // switch to bank 3, no drain wait
    switch_req = 1; switch_id = 5'd3; step();
    switch_req = 0;
    check("lit_b3_c1_stall", 32'(cpu_stall), 32'd1);
    check("lit_b3_c1_sel", 32'(bank_sel), 32'd0);
    step(); check("lit_b3_c2_sel", 32'(bank_sel), 32'd3);
    step(); check("lit_b3_c3_stall", 32'(cpu_stall), 32'd1);
    step(); check("lit_b3_c4_done", 32'(switch_done), 32'd1);
    check("lit_b3_c4_count", 32'(switch_count), 32'd1);
    step(); check("lit_b3_c5_ready", 32'(switch_ready), 32'd1);
    step(2);

    // bank 5 with cache_busy high for 4 DRAIN edges
    cache_busy = 1; switch_req = 1; switch_id = 5'd5; step();
    switch_req = 0;
    step(4);
    check("lit_b5_c5_sel", 32'(bank_sel), 32'd3);
    cache_busy = 0;
    step(); check("lit_b5_c6_sel", 32'(bank_sel), 32'd5);
    step(2); check("lit_b5_c8_done", 32'(switch_done), 32'd1);
    step(3);

    // same bank
    switch_req = 1; switch_id = 5'd5; step();
    switch_req = 0;
    check("lit_same_done", 32'(switch_done), 32'd1);
    check("lit_same_stall", 32'(cpu_stall), 32'd0);
    check("lit_same_count", 32'(switch_count), 32'd2);
    step(); check("lit_same_ready", 32'(switch_ready), 32'd1);
    step(2);

    // invalid IDs 9 and 31
    switch_req = 1; switch_id = 5'd9; step();
    switch_req = 0;
    check("lit_err9", 32'(switch_err), 32'd1);
    check("lit_err9_ready", 32'(switch_ready), 32'd1);
    step(); check("lit_err9_pulse_end", 32'(switch_err), 32'd0);
    switch_req = 1; switch_id = 5'd31; step();
    switch_req = 0;
    check("lit_err31", 32'(switch_err), 32'd1);
    check("lit_err31_sel", 32'(bank_sel), 32'd5);
    step(2);

    // request held during SETTLE is taken only once ready returns
    switch_req = 1; switch_id = 5'd4; step();
    switch_req = 0; step();
    switch_req = 1; switch_id = 5'd2; step(2);
    check("lit_hold_c4_done", 32'(switch_done), 32'd1);
    check("lit_hold_c4_sel", 32'(bank_sel), 32'd4);
    step(); check("lit_hold_c5_ready", 32'(switch_ready), 32'd1);
    step(); switch_req = 0;
    check("lit_hold_c6_stall", 32'(cpu_stall), 32'd1);
    check("lit_hold_c6_sel", 32'(bank_sel), 32'd4);
    step(); check("lit_hold_c7_sel", 32'(bank_sel), 32'd2);
    step(5);

    // reset during DRAIN
    cache_busy = 1; switch_req = 1; switch_id = 5'd7; step();
    switch_req = 0; step();
    RESET = 1; step();
    check("lit_rst_drain_sel", 32'(bank_sel), 32'd0);
    check("lit_rst_drain_ready", 32'(switch_ready), 32'd1);
    check("lit_rst_drain_count", 32'(switch_count), 32'd0);
    RESET = 0; cache_busy = 0; step(2);

    // reset during SETTLE
    switch_req = 1; switch_id = 5'd6; step();
    switch_req = 0; step();
    RESET = 1; step();
    check("lit_rst_settle_done", 32'(switch_done), 32'd0);
    check("lit_rst_settle_sel", 32'(bank_sel), 32'd0);
    check("lit_rst_settle_stall", 32'(cpu_stall), 32'd0);
    RESET = 0; step(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      switch_req = ($urandom_range(0, 2) == 0);
      switch_id  = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(NB, 31))
                                              : SW'($urandom_range(0, NB - 1));
      cache_busy = ($urandom_range(0, 1) == 1);
      RESET      = ($urandom_range(0, 299) == 0);
      step();
    end
    switch_req = 0; RESET = 0; cache_busy = 0;
    step(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_switch_controller.md
# cache_switch_controller

Sequences the 5-bit select of the cache-bank output multiplexer in response to OS context-switch requests. Accepts a target bank ID from the context-switch logic and waits for the outgoing cache to finish its in-flight access. It then retargets the mux, stalls the CPU for a fixed settle window, and reports completion. It sits between the context-switch/CSR logic and the bank-select input of the cache data-path mux.

## Interface
Parameters:
- NUM_BANKS, 9: number of valid bank IDs (0..NUM_BANKS-1); legal range 2..32
- SEL_W, 5: select/bank-ID width
- SETTLE_CYCLES, 2: stall cycles after the select changes; legal range 1..15
- CNT_W, 16: switch-counter width

Ports:
- CLK  in  1  single clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- switch_req  in  1  request valid; the request is accepted on the edge where switch_req && switch_ready
- switch_id  in  SEL_W  target bank ID; sampled only on acceptance
- cache_busy  in  1  active cache has an access in flight
- switch_ready  out  1  high only in IDLE
- bank_sel  out  SEL_W  registered mux select; reset value 0
- cpu_stall  out  1  high in DRAIN and SETTLE; reset value 0
- switch_done  out  1  one-cycle pulse in DONE; reset value 0
- switch_err  out  1  one-cycle pulse after an invalid ID is accepted; reset value 0
- switch_count  out  CNT_W  completed real switches, saturating; reset value 0

## Operation
- States: IDLE, DRAIN, SETTLE, DONE. Reset enters IDLE.
- Accepting a request in IDLE latches switch_id into target. The next state depends on target:
  - target >= NUM_BANKS: stay in IDLE; switch_err pulses the next cycle; bank_sel, cpu_stall and the counter are unchanged.
  - target == bank_sel (same bank): go to DONE; no stall and no counter increment.
  - Otherwise: go to DRAIN.
- DRAIN holds while cache_busy=1. On the edge where cache_busy=0:
  - bank_sel <= target
  - settle counter <= SETTLE_CYCLES-1
  - next state SETTLE
- SETTLE decrements the counter each cycle. On the edge where counter==0:
  - next state DONE
  - switch_count increments, holding at all-ones
- DONE always returns to IDLE on the next edge.
- switch_req while switch_ready=0 is ignored, not queued. The requester must hold the request until it sees switch_ready.
- cache_busy is ignored outside DRAIN.
- bank_sel changes only on the DRAIN→SETTLE edge or on reset.
- RESET mid-operation, in any state: next cycle is IDLE with all outputs at their reset values, bank_sel=0 and switch_count=0. Any pending target is discarded.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from input to output.
- The request is accepted at edge 0, with cache_busy=0 and SETTLE_CYCLES=2:
  - cycle 1: DRAIN; cpu_stall=1
  - cycle 2: bank_sel shows the new ID; SETTLE
  - cycle 3: SETTLE
  - cycle 4: switch_done=1; cpu_stall=0
  - cycle 5: switch_ready=1
- General latency:
  - new bank_sel is visible 2 + D cycles after acceptance, where D = number of cycles cache_busy stays high in DRAIN
  - switch_done is visible 2 + D + SETTLE_CYCLES cycles after acceptance
- Same-bank request: switch_done in cycle 1; switch_ready again in cycle 2; cpu_stall never asserted.
- Invalid request: switch_err in cycle 1; switch_ready stays high throughout.
- cpu_stall rises one cycle before bank_sel changes, so no access launches on a stale select.

## Structure
- Shared package/header cache_switch_pkg:
  - state encodings
  - DEFAULT_BANK_SEL = 0
  - the SEL_W constant shared with the bank mux
- One sub-module, settle_timer:
  - load/decrement counter of width clog2(SETTLE_CYCLES)+1
  - outputs an expired flag
  - instantiated once; the FSM lives in the top level

## Test plan
- Reset, then switch to bank 3 with cache_busy=0 and SETTLE_CYCLES=2 -> bank_sel=3 at cycle 2, stall in cycles 1–3, done at cycle 4, switch_count=1.
- Request bank 5 with cache_busy high for 4 cycles -> remains in DRAIN; bank_sel stays at the old value until cache_busy falls; bank_sel=5 at cycle 6, done at cycle 8.
- Request the bank equal to the current bank_sel -> done at cycle 1, cpu_stall=0 throughout, count unchanged.
- Request ID 9, then ID 31 (NUM_BANKS=9) -> switch_err pulses each time; bank_sel, count and stall are unchanged.
- Assert switch_req with ID 2 during SETTLE of a switch to bank 4 -> request ignored; final bank_sel=4; the held request is accepted only after switch_ready returns.
- Assert RESET during DRAIN and, separately, during SETTLE -> next cycle IDLE, bank_sel=0, count=0, no done pulse.
